// File: rtl/stream_writer.sv
// Sinks a valid/ready word stream into one BRAM write port, writing consecutive
// addresses in [start, limit) and raising done when the range is filled.
module stream_writer #(
  parameter int DWIDTH = 32,
  parameter int WORDS = 1 << 12,
  localparam int SIZE = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DWIDTH-1:0] start,
  input  logic [DWIDTH-1:0] limit,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] datai,
  output logic              in_ready,
  output logic              we,
  output logic [SIZE-1:0]   addr,
  output logic [DWIDTH-1:0] datao,
  output logic [DWIDTH-1:0] count,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [DWIDTH-1:0] ONE = {{(DWIDTH-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            next_state_s;
  logic              in_ready_r;
  logic              we_r;
  logic              done_r;
  logic [SIZE-1:0]   addr_r;
  logic [DWIDTH-1:0] datao_r;
  logic [DWIDTH-1:0] count_r;
  logic [DWIDTH-1:0] ptr_r;
  logic [DWIDTH-1:0] lim_r;
  logic [DWIDTH-1:0] ptr_inc_s;
  logic              accept_s;
  logic              launch_s;

  // Next-state decode; an abort (en low in RUN) wins over reaching the limit.
  always_comb begin
    next_state_s = state_r;
    ptr_inc_s    = ptr_r + ONE;
    accept_s     = in_ready_r & in_valid;
    launch_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (en) begin
          launch_s     = 1'b1;
          next_state_s = (limit <= start) ? FIN : RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (!en) begin
          next_state_s = IDLE;
        end else if (accept_s && (ptr_inc_s == lim_r)) begin
          next_state_s = FIN;
        end else begin
          next_state_s = RUN;
        end
      end
      FIN: begin
        if (!en) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = FIN;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, handshake and BRAM write-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b0;
      we_r       <= 1'b0;
      done_r     <= 1'b0;
      addr_r     <= {SIZE{1'b0}};
      datao_r    <= {DWIDTH{1'b0}};
      count_r    <= {DWIDTH{1'b0}};
      ptr_r      <= {DWIDTH{1'b0}};
      lim_r      <= {DWIDTH{1'b0}};
    end else begin
      state_r    <= next_state_s;
      in_ready_r <= (next_state_s == RUN);
      done_r     <= (next_state_s == FIN);
      we_r       <= accept_s;
      if (accept_s) begin
        addr_r  <= ptr_r[SIZE-1:0];
        datao_r <= datai;
        ptr_r   <= ptr_inc_s;
        count_r <= count_r + ONE;
      end
      if (launch_s) begin
        ptr_r   <= start;
        lim_r   <= limit;
        count_r <= {DWIDTH{1'b0}};
      end
    end
  end

  assign in_ready = in_ready_r;
  assign we       = we_r;
  assign addr     = addr_r;
  assign datao    = datao_r;
  assign count    = count_r;
  assign done     = done_r;

endmodule
